// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the BIP1 data RAM arbiter.
//   - FSM state encoding of the access sequencer.
//   - Requester port indices (port 0 = CPU datapath, port 1 = debug/UART dump).
package data_mem_arb_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] READ_RSP = 2'd2;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
//   Requester side : i_reqN, i_weN, i_addrN, i_wdataN -> arbiter
//                    o_gntN, o_rvalidN, o_rdataN     <- arbiter
//   RAM side       : o_mem_addr, o_mem_wdata, o_mem_we -> RAM
//                    i_mem_rdata                       <- RAM (1-cycle latency)
// Modport slave is the arbiter view, master is the requester/RAM view.
interface data_mem_arbiter_if #(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
);

  logic                  i_req0,    i_req1;
  logic                  i_we0,     i_we1;
  logic [ADDR_WIDTH-1:0] i_addr0,   i_addr1;
  logic [RAM_WIDTH-1:0]  i_wdata0,  i_wdata1;
  logic                  o_gnt0,    o_gnt1;
  logic                  o_rvalid0, o_rvalid1;
  logic [RAM_WIDTH-1:0]  o_rdata0,  o_rdata1;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [RAM_WIDTH-1:0]  o_mem_wdata;
  logic                  o_mem_we;
  logic [RAM_WIDTH-1:0]  i_mem_rdata;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  i_mem_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    output o_mem_addr, o_mem_wdata, o_mem_we
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    output i_mem_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    input  o_mem_addr, o_mem_wdata, o_mem_we
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: two-request picker producing a one-hot winner.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : pending requests (bit index = port)
//   adv      : the current winner is being taken; update the last-winner state
//   gnt[1:0] : one-hot winner (combinational)
// Build option: define DATA_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0
// always wins a tie, no last-winner state). Default is 2-way round-robin.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, adv};

  always_comb begin
    gnt           = 2'b00;
    gnt[PORT_CPU] = req[PORT_CPU];
    gnt[PORT_DBG] = req[PORT_DBG] & ~req[PORT_CPU];
  end
`else
  // 1 when port 1 won most recently; reset to 1 so port 0 takes the first tie.
  logic last;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = 2'b00;
      if (last) gnt[PORT_CPU] = 1'b1;
      else      gnt[PORT_DBG] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last <= 1'b1;
    else if (adv) last <= gnt[PORT_DBG];
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port, no-change, 1-cycle-latency BIP1
// data RAM between port 0 (CPU) and port 1 (debug/UART dump).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : requester handshakes (req/we/addr/wdata -> gnt/rvalid/rdata)
//                  and the registered RAM drive (o_mem_addr/wdata/we, i_mem_rdata)
// Sequence: IDLE (pick + register) -> ACCESS (grant, RAM op at cycle end)
//           -> READ_RSP (capture RAM data, rvalid next cycle) for reads only.
// Build option DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  data_mem_arbiter_if.slave   bus
);

  logic [1:0]            state;
  logic [1:0]            req;
  logic [1:0]            win;
  logic                  adv;
  logic                  owner;      // 1 = current access belongs to port 1
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]  sel_wdata;

  assign req = {bus.i_req1, bus.i_req0};
  assign adv = (state == IDLE) && (|req);

  rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .req (req),
    .adv (adv),
    .gnt (win)
  );

  always_comb begin
    sel_we    = bus.i_we0;
    sel_addr  = bus.i_addr0;
    sel_wdata = bus.i_wdata0;
    if (win[PORT_DBG]) begin
      sel_we    = bus.i_we1;
      sel_addr  = bus.i_addr1;
      sel_wdata = bus.i_wdata1;
    end
  end

  // Reset clears o_mem_we asynchronously, so a write whose ACCESS edge has not
  // yet arrived is aborted; an in-flight read is simply forgotten.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      bus.o_gnt0      <= 1'b0;
      bus.o_gnt1      <= 1'b0;
      bus.o_rvalid0   <= 1'b0;
      bus.o_rvalid1   <= 1'b0;
      bus.o_rdata0    <= '0;
      bus.o_rdata1    <= '0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_mem_we    <= 1'b0;
    end else begin
      bus.o_gnt0    <= 1'b0;
      bus.o_gnt1    <= 1'b0;
      bus.o_rvalid0 <= 1'b0;
      bus.o_rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (adv) begin
            owner           <= win[PORT_DBG];
            bus.o_mem_addr  <= sel_addr;
            bus.o_mem_wdata <= sel_wdata;
            bus.o_mem_we    <= sel_we;
            bus.o_gnt0      <= win[PORT_CPU];
            bus.o_gnt1      <= win[PORT_DBG];
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.o_mem_we) begin
            bus.o_mem_we <= 1'b0;
            state        <= IDLE;
          end else begin
            state <= READ_RSP;
          end
        end
        READ_RSP: begin
          if (owner) begin
            bus.o_rdata1  <= bus.i_mem_rdata;
            bus.o_rvalid1 <= 1'b1;
          end else begin
            bus.o_rdata0  <= bus.i_mem_rdata;
            bus.o_rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [15:0] data;
    bit          pulse;
    int          gap;
  } txn_t;

  typedef struct {
    int          port;
    int          cyc;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.RAM_WIDTH(16), .ADDR_WIDTH(10)) bus ();

  data_mem_arbiter #(.RAM_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Data RAM: single port, no-change, one cycle read latency.
  logic [15:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    else              bus.i_mem_rdata     <= ram[bus.o_mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a single shared server that becomes free 2 cycles after
  // taking a write and 3 cycles after taking a read; ties go round-robin.
  logic [15:0] mmem [0:1023];
  bit   mpend [2];
  txn_t mtx   [2];
  int   free_at = 0;
  int   mlast   = 1;
  ev_t  gq[$];
  ev_t  rq[$];

  // Requester drivers
  txn_t pq [2][$];
  bit   busy [2];
  bit   pulse_drop [2];
  int   wait_cnt [2];
  int   gapc [2];
  bit   last_g [2];

  task automatic set_req(input int p, input bit r);
    if (p == 0) bus.i_req0 = r;
    else        bus.i_req1 = r;
  endtask

  task automatic drive(input int p, input txn_t t);
    if (p == 0) begin
      bus.i_req0 = 1'b1; bus.i_we0 = t.we; bus.i_addr0 = t.addr; bus.i_wdata0 = t.data;
    end else begin
      bus.i_req1 = 1'b1; bus.i_we1 = t.we; bus.i_addr1 = t.addr; bus.i_wdata1 = t.data;
    end
  endtask

  task automatic model_step();
    int  w;
    ev_t e;
    if (cyc >= free_at && (mpend[0] || mpend[1])) begin
      if (mpend[0] && mpend[1]) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (mlast == 0) ? 1 : 0;
`endif
      end else begin
        w = mpend[0] ? 0 : 1;
      end
      mpend[w] = 1'b0;
      mlast    = w;
      e.port = w; e.cyc = cyc + 1; e.data = '0;
      gq.push_back(e);
      if (mtx[w].we) begin
        mmem[mtx[w].addr] = mtx[w].data;
        free_at = cyc + 2;
      end else begin
        e.cyc = cyc + 3; e.data = mmem[mtx[w].addr];
        rq.push_back(e);
        free_at = cyc + 3;
      end
    end
  endtask

  task automatic step_raw();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    bit g [2];
    step_raw();
    g[0] = bus.o_gnt0;
    g[1] = bus.o_gnt1;
    for (int p = 0; p < 2; p++) begin
      if (pulse_drop[p]) begin
        set_req(p, 1'b0);
        pulse_drop[p] = 1'b0;
        if (mpend[p]) begin mpend[p] = 1'b0; busy[p] = 1'b0; end
      end
      if (busy[p]) begin
        if (last_g[p]) begin
          busy[p] = 1'b0;
          set_req(p, 1'b0);
        end else if (++wait_cnt[p] > 60) begin
          check($sformatf("gnt_timeout_port%0d", p), 32'd0, 32'd1);
          busy[p] = 1'b0; mpend[p] = 1'b0;
          set_req(p, 1'b0);
        end
      end
      if (!busy[p] && pq[p].size() > 0) begin
        if (gapc[p] < pq[p][0].gap) begin
          gapc[p]++;
        end else begin
          txn_t t;
          t = pq[p].pop_front();
          gapc[p] = 0;
          busy[p] = 1'b1; wait_cnt[p] = 0;
          drive(p, t);
          mpend[p] = 1'b1; mtx[p] = t;
          if (t.pulse) pulse_drop[p] = 1'b1;
        end
      end
    end
    last_g = g;
    model_step();
  endtask

  task automatic push(input int p, input bit we, input logic [9:0] a, input logic [15:0] d,
                      input int gap, input bit pulse);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.gap = gap; t.pulse = pulse;
    pq[p].push_back(t);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || busy[0] || busy[1] ||
            gq.size() > 0 || rq.size() > 0 || cyc < free_at) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) check("drain_timeout", 32'd0, 32'd1);
    step();
    step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.o_gnt0, bus.o_gnt1, bus.o_rvalid0, bus.o_rvalid1, bus.o_mem_we}, 32'd0);
    check({tag, "_mem_addr"}, bus.o_mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'd0);
    check({tag, "_rdata"}, {bus.o_rdata1, bus.o_rdata0}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      set_req(p, 1'b0);
      busy[p] = 1'b0; mpend[p] = 1'b0; pulse_drop[p] = 1'b0; last_g[p] = 1'b0; gapc[p] = 0;
    end
    gq.delete();
    rq.delete();
    #1;
    check_outputs_zero("reset_now");
    repeat (2) step_raw();
    check_outputs_zero("reset_held");
    rst = 1'b0;
    mlast   = 1;
    free_at = cyc;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      check("gnt_exclusive", {31'd0, bus.o_gnt0 & bus.o_gnt1}, 32'd0);
      check("rvalid_exclusive", {31'd0, bus.o_rvalid0 & bus.o_rvalid1}, 32'd0);
      if (bus.o_gnt0 || bus.o_gnt1) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", {bus.o_gnt1, bus.o_gnt0}, 32'd0);
        end else begin
          e = gq.pop_front();
          check("gnt_port", {31'd0, bus.o_gnt1}, e.port);
          check("gnt_cycle", cyc, e.cyc);
        end
      end
      if (bus.o_rvalid0 || bus.o_rvalid1) begin
        if (rq.size() == 0) begin
          check("rvalid_unexpected", {bus.o_rvalid1, bus.o_rvalid0}, 32'd0);
        end else begin
          e = rq.pop_front();
          check("rvalid_port", {31'd0, bus.o_rvalid1}, e.port);
          check("rvalid_cycle", cyc, e.cyc);
          check("rdata", bus.o_rvalid1 ? bus.o_rdata1 : bus.o_rdata0, e.data);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [9:0] addrs [8];

  initial begin
    bus.i_req0 = 0; bus.i_we0 = 0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
    bus.i_req1 = 0; bus.i_we1 = 0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    addrs = '{10'h000, 10'h001, 10'h005, 10'h0AA, 10'h155, 10'h010, 10'h020, 10'h3FF};

    step_raw();
    do_reset();

    // Give every address used below a known content.
    for (int i = 0; i < 8; i++) push(0, 1'b1, addrs[i], 16'h0000, 0, 1'b0);
    push(0, 1'b1, 10'h010, 16'h1111, 0, 1'b0);
    push(0, 1'b1, 10'h020, 16'h2222, 0, 1'b0);
    push(0, 1'b1, 10'h3FF, 16'h0F0F, 0, 1'b0);
    wait_idle();

    // Single write then read on port 0.
    push(0, 1'b1, 10'h005, 16'hBEEF, 0, 1'b0);
    push(0, 1'b0, 10'h005, 16'h0000, 0, 1'b0);
    wait_idle();
    check("rdata0_beef_held", bus.o_rdata0, 32'hBEEF);

    // Simultaneous reads after reset: port 0 first.
    do_reset();
    push(0, 1'b0, 10'h010, 16'h0000, 0, 1'b0);
    push(1, 1'b0, 10'h020, 16'h0000, 0, 1'b0);
    wait_idle();
    check("rdata0_1111", bus.o_rdata0, 32'h1111);
    check("rdata1_2222", bus.o_rdata1, 32'h2222);

    // Fairness: both ports keep requesting.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 10'h010, 16'h0000, 0, 1'b0);
      push(1, 1'b0, 10'h020, 16'h0000, 0, 1'b0);
    end
    wait_idle();

    // Write on port 1 and read on port 0 of the top address at the same time.
    push(1, 1'b1, 10'h3FF, 16'hA5A5, 0, 1'b0);
    push(0, 1'b0, 10'h3FF, 16'h0000, 0, 1'b0);
    wait_idle();
    push(1, 1'b0, 10'h3FF, 16'h0000, 0, 1'b0);
    wait_idle();
    check("rdata1_a5a5", bus.o_rdata1, 32'hA5A5);

    // Request pulsed for one cycle on port 1 still completes.
    push(1, 1'b0, 10'h020, 16'h0000, 0, 1'b1);
    wait_idle();

    // Reset while the write of 0x7777 to 0x001 is in ACCESS.
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b1; bus.i_addr0 = 10'h001; bus.i_wdata0 = 16'h7777;
    step_raw();
    check("midwrite_gnt0", {31'd0, bus.o_gnt0}, 32'd1);
    check("midwrite_mem_we", {31'd0, bus.o_mem_we}, 32'd1);
    do_reset();
    push(0, 1'b0, 10'h001, 16'h0000, 0, 1'b0);
    wait_idle();
    check("after_abort_rdata0", bus.o_rdata0, 32'h0000);

    // Randomized traffic over a small address set.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        push(p, bit'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)],
             16'($urandom), $urandom_range(0, 3), 1'b0);
    end
    wait_idle();

    check("gnt_queue_drained", gq.size(), 32'd0);
    check("rvalid_queue_drained", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
